// File: rtl/jac_sequencer.sv
// jac_sequencer: multi-cycle fetch/decode/exec/writeback controller for the Jac1-8 core.
// Optional macro JAC_SEQ_SINGLE_STEP_EN adds a step input; WB then always returns to IDLE.
module jac_sequencer #(
  parameter int PC_WIDTH      = 8,
  parameter int NumOpCodeBits = 5,
  parameter int NumStatusBits = 3,
  parameter logic [NumOpCodeBits-1:0] HALT_OPCODE = 5'b1_1111,
  parameter logic [NumOpCodeBits-1:0] GOTO_OPCODE = 5'b1_0000,
  parameter logic [NumOpCodeBits-1:0] IFZ_OPCODE  = 5'b1_0001,
  parameter logic [NumOpCodeBits-1:0] IFNZ_OPCODE = 5'b1_0010,
  parameter logic [NumOpCodeBits-1:0] IFEQ_OPCODE = 5'b1_0011,
  parameter logic [NumOpCodeBits-1:0] IFST_OPCODE = 5'b1_0100,
  parameter logic [NumOpCodeBits-1:0] IFGT_OPCODE = 5'b1_0101
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
`ifdef JAC_SEQ_SINGLE_STEP_EN
  input  logic                     step,
`endif
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_adr,
  input  logic                     imem_ack,
  output logic                     ir_load,
  input  logic [NumOpCodeBits-1:0] opcode,
  input  logic [PC_WIDTH-1:0]      literal_adr,
  input  logic [NumStatusBits-1:0] status,
  input  logic                     wr_en_dec,
  input  logic                     stat_wr_en_dec,
  output logic                     reg_wr_strobe,
  output logic                     stat_wr_strobe,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] next_pc_reg, next_pc_next;
  logic [PC_WIDTH-1:0] branch_pc;
  logic                skip, take_goto;
  logic                flag_z, flag_b;
  logic                start_req, wb_continue;
  logic                unused_status;

  assign flag_z        = status[0];
  assign flag_b        = status[2];
  assign unused_status = ^status;

`ifdef JAC_SEQ_SINGLE_STEP_EN
  assign start_req   = run | step;
  assign wb_continue = 1'b0;
`else
  assign start_req   = run;
  assign wb_continue = run;
`endif

  // Branch resolution; the PC adder wraps naturally at PC_WIDTH bits.
  always_comb begin
    skip      = 1'b0;
    take_goto = 1'b0;
    case (opcode)
      GOTO_OPCODE:             take_goto = 1'b1;
      IFZ_OPCODE, IFEQ_OPCODE: skip = flag_z;
      IFNZ_OPCODE:             skip = !flag_z;
      IFST_OPCODE:             skip = flag_b;
      IFGT_OPCODE:             skip = !flag_z && !flag_b;
      default:                 skip = 1'b0;
    endcase
    branch_pc = take_goto ? literal_adr
                          : pc_reg + (skip ? PC_WIDTH'(2) : PC_WIDTH'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      next_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      next_pc_reg <= next_pc_next;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    next_pc_next   = next_pc_reg;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    reg_wr_strobe  = 1'b0;
    stat_wr_strobe = 1'b0;
    halted         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_req) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = (opcode == HALT_OPCODE) ? HALT : EXEC;
      end
      EXEC: begin
        next_pc_next = branch_pc;
        state_next   = WB;
      end
      WB: begin
        reg_wr_strobe  = wr_en_dec;
        stat_wr_strobe = stat_wr_en_dec;
        pc_next        = next_pc_reg;
        state_next     = wb_continue ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_adr = pc_reg;
  assign pc       = pc_reg;

endmodule

// File: tb/tb_jac_sequencer.sv
// Self-checking bench for jac_sequencer: directed scenarios plus randomized instructions
// checked against a behavioural next-PC model.
module tb_jac_sequencer;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_GOTO = 5'h10;
  localparam logic [4:0] OP_IFZ  = 5'h11;
  localparam logic [4:0] OP_IFNZ = 5'h12;
  localparam logic [4:0] OP_IFEQ = 5'h13;
  localparam logic [4:0] OP_IFST = 5'h14;
  localparam logic [4:0] OP_IFGT = 5'h15;
  localparam logic [4:0] OP_HALT = 5'h1F;
`ifdef JAC_SEQ_SINGLE_STEP_EN
  localparam bit WB_TO_IDLE = 1'b1;
`else
  localparam bit WB_TO_IDLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step_drv = 1'b0;
  logic       imem_req;
  logic [7:0] imem_adr;
  logic       imem_ack = 1'b0;
  logic       ir_load;
  logic [4:0] opcode = '0;
  logic [7:0] literal_adr = '0;
  logic [2:0] status = '0;
  logic       wr_en_dec = 1'b0;
  logic       stat_wr_en_dec = 1'b0;
  logic       reg_wr_strobe, stat_wr_strobe;
  logic [7:0] pc;
  logic       halted;

  int tests = 0;
  int failed = 0;
  int model_pc = 0;

  logic [7:0] obs_adr, obs_pc_after;
  int         obs_req_cycles, obs_ir_loads, obs_reg_strobes, obs_stat_strobes;
  bit         obs_pc_stable, obs_req_after, obs_halted;

  always #5 clk = ~clk;

  jac_sequencer #(
    .PC_WIDTH(8), .NumOpCodeBits(5), .NumStatusBits(3),
    .HALT_OPCODE(OP_HALT), .GOTO_OPCODE(OP_GOTO), .IFZ_OPCODE(OP_IFZ),
    .IFNZ_OPCODE(OP_IFNZ), .IFEQ_OPCODE(OP_IFEQ), .IFST_OPCODE(OP_IFST),
    .IFGT_OPCODE(OP_IFGT)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef JAC_SEQ_SINGLE_STEP_EN
    .step(step_drv),
`endif
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack), .ir_load(ir_load),
    .opcode(opcode), .literal_adr(literal_adr), .status(status),
    .wr_en_dec(wr_en_dec), .stat_wr_en_dec(stat_wr_en_dec),
    .reg_wr_strobe(reg_wr_strobe), .stat_wr_strobe(stat_wr_strobe),
    .pc(pc), .halted(halted)
  );

  // Reference: what the program counter becomes after one instruction.
  function automatic int model_next(int cur, logic [4:0] op, logic [7:0] lit, logic [2:0] st);
    bit z = st[0];
    bit b = st[2];
    int inc = 1;
    if (op == OP_GOTO) return int'(lit);
    if ((op == OP_IFZ || op == OP_IFEQ) && z) inc = 2;
    if (op == OP_IFNZ && !z) inc = 2;
    if (op == OP_IFST && b) inc = 2;
    if (op == OP_IFGT && !z && !b) inc = 2;
    return (cur + inc) % 256;
  endfunction

  // Runs one instruction: waits for the fetch, acks after 'delay' cycles, then
  // observes DECODE/EXEC/WB and the following cycle. Called at a negedge instant.
  task automatic do_instr(input logic [4:0] op, input logic [7:0] lit, input logic [2:0] st,
                          input logic wr, input logic swr, input int delay,
                          input bit stop, input bit use_step);
    int waited = 0;
    logic [7:0] pc_before;
    obs_req_cycles = 0; obs_ir_loads = 0; obs_reg_strobes = 0; obs_stat_strobes = 0;
    obs_pc_stable = 1'b1;
    run = !use_step;
    step_drv = use_step;
    opcode = op; literal_adr = lit; status = st; wr_en_dec = wr; stat_wr_en_dec = swr;
    #1;
    while (imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 20) begin
      tests++; failed++;
      $display("[TB] FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, waited);
    end
    step_drv = 1'b0;
    obs_adr = imem_adr;
    pc_before = pc;
    for (int k = 0; k <= delay; k++) begin
      imem_ack = (k == delay);
      #1;
      if (imem_req === 1'b1) obs_req_cycles++;
      if (ir_load === 1'b1) obs_ir_loads++;
      if (pc !== pc_before) obs_pc_stable = 1'b0;
      @(negedge clk); #1;
    end
    for (int c = 1; c <= 4; c++) begin
      imem_ack = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stop && c == 1) run = 1'b0;
      #1;
      if (reg_wr_strobe === 1'b1) obs_reg_strobes++;
      if (stat_wr_strobe === 1'b1) obs_stat_strobes++;
      if (c < 4) begin
        if (ir_load === 1'b1) obs_ir_loads++;
        if (pc !== pc_before) obs_pc_stable = 1'b0;
        @(negedge clk); #1;
      end else begin
        obs_pc_after  = pc;
        obs_req_after = imem_req;
        obs_halted    = halted;
      end
    end
    $display("[TB] instr op=%h lit=%h st=%b adr=%h pc_after=%h strobes=%0d/%0d",
             op, lit, st, obs_adr, obs_pc_after, obs_reg_strobes, obs_stat_strobes);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (pc !== 8'h00) begin failed++; $display("[TB] FAIL reset_pc: got %h required 00", pc); end
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL reset_req: got %b required 0", imem_req); end
    tests++; if (ir_load !== 1'b0 || halted !== 1'b0) begin failed++;
      $display("[TB] FAIL reset_ir_halt: got %b%b required 00", ir_load, halted); end
    tests++; if (reg_wr_strobe !== 1'b0 || stat_wr_strobe !== 1'b0) begin failed++;
      $display("[TB] FAIL reset_strobes: got %b%b required 00", reg_wr_strobe, stat_wr_strobe); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL idle_no_run: req=%b required 0", imem_req); end
    model_pc = 0;
  endtask

  task automatic test_fetch_wait();
    logic [7:0] exp = 8'(model_next(model_pc, OP_ADD, 8'h00, 3'b000));
    do_instr(OP_ADD, 8'h00, 3'b000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    tests++; if (obs_req_cycles !== 4) begin failed++; $display("[TB] FAIL wait_req_cycles: got %0d required 4", obs_req_cycles); end
    tests++; if (obs_ir_loads !== 1) begin failed++; $display("[TB] FAIL wait_ir_load: got %0d required 1", obs_ir_loads); end
    tests++; if (!obs_pc_stable) begin failed++; $display("[TB] FAIL wait_pc_stable: got 0 required 1"); end
    tests++; if (obs_pc_after !== exp) begin failed++; $display("[TB] FAIL wait_pc_after: got %h required %h", obs_pc_after, exp); end
    model_pc = int'(exp);
  endtask

  task automatic test_add();
    do_instr(OP_GOTO, 8'h10, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    model_pc = 16'h10;
    do_instr(OP_ADD, 8'h5A, 3'b111, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    tests++; if (obs_adr !== 8'h10) begin failed++; $display("[TB] FAIL add_adr: got %h required 10", obs_adr); end
    tests++; if (obs_reg_strobes !== 1 || obs_stat_strobes !== 1) begin failed++;
      $display("[TB] FAIL add_strobes: got %0d/%0d required 1/1", obs_reg_strobes, obs_stat_strobes); end
    tests++; if (obs_pc_after !== 8'h11) begin failed++; $display("[TB] FAIL add_pc: got %h required 11", obs_pc_after); end
    tests++; if (obs_req_after !== !WB_TO_IDLE) begin failed++;
      $display("[TB] FAIL add_refetch: got %b required %b", obs_req_after, !WB_TO_IDLE); end
    model_pc = 16'h11;
  endtask

  task automatic test_branches();
    logic [4:0] ops [5] = '{OP_GOTO, OP_IFZ, OP_IFZ, OP_IFGT, OP_IFGT};
    logic [2:0] sts [5] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100};
    logic [7:0] lits[5] = '{8'h42, 8'h99, 8'h99, 8'h99, 8'h99};
    logic [7:0] exps[5] = '{8'h42, 8'h22, 8'h21, 8'h22, 8'h21};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        do_instr(OP_GOTO, 8'h20, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        model_pc = 32;
      end
      do_instr(ops[i], lits[i], sts[i], 1'b0, 1'b0, 1, 1'b0, 1'b0);
      tests++; if (obs_pc_after !== exps[i]) begin failed++;
        $display("[TB] FAIL branch_%0d: got %h required %h", i, obs_pc_after, exps[i]); end
      model_pc = int'(exps[i]);
      if (i == 0) begin
        do_instr(OP_NOP, 8'h00, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tests++; if (obs_adr !== 8'h42) begin failed++; $display("[TB] FAIL goto_adr: got %h required 42", obs_adr); end
        model_pc = 16'h43;
      end
    end
  endtask

  task automatic test_wrap();
    do_instr(OP_GOTO, 8'hFF, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_instr(OP_IFNZ, 8'h00, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tests++; if (obs_pc_after !== 8'h01) begin failed++; $display("[TB] FAIL wrap_skip: got %h required 01", obs_pc_after); end
    do_instr(OP_GOTO, 8'hFF, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_instr(OP_NOP, 8'h00, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tests++; if (obs_pc_after !== 8'h00) begin failed++; $display("[TB] FAIL wrap_nop: got %h required 00", obs_pc_after); end
    model_pc = 0;
  endtask

  task automatic test_random(input int n);
    logic [4:0] pool [6] = '{OP_GOTO, OP_IFZ, OP_IFNZ, OP_IFEQ, OP_IFST, OP_IFGT};
    for (int i = 0; i < n; i++) begin
      logic [4:0] op;
      logic [7:0] lit = 8'($urandom);
      logic [2:0] st  = 3'($urandom);
      logic wr = 1'($urandom), swr = 1'($urandom);
      logic [7:0] exp;
      if ($urandom_range(0, 2) == 0) begin
        op = 5'($urandom_range(0, 30));
      end else begin
        op = pool[$urandom_range(0, 5)];
      end
      exp = 8'(model_next(model_pc, op, lit, st));
      do_instr(op, lit, st, wr, swr, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      tests++; if (obs_adr !== 8'(model_pc)) begin failed++;
        $display("[TB] FAIL rand_adr_%0d: got %h required %h", i, obs_adr, 8'(model_pc)); end
      tests++; if (obs_pc_after !== exp) begin failed++;
        $display("[TB] FAIL rand_pc_%0d: got %h required %h", i, obs_pc_after, exp); end
      tests++; if (obs_reg_strobes !== int'(wr) || obs_stat_strobes !== int'(swr) || obs_ir_loads !== 1) begin failed++;
        $display("[TB] FAIL rand_pulses_%0d: got %0d/%0d/%0d required %0d/%0d/1", i,
                 obs_reg_strobes, obs_stat_strobes, obs_ir_loads, wr, swr); end
      model_pc = int'(exp);
    end
  endtask

  task automatic test_run_stop();
    int reqs = 0;
    logic [7:0] exp = 8'(model_next(model_pc, OP_NOP, 8'h00, 3'b000));
    do_instr(OP_NOP, 8'h00, 3'b000, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    tests++; if (obs_req_after !== 1'b0 || obs_pc_after !== exp) begin failed++;
      $display("[TB] FAIL stop_idle: req=%b pc=%h required 0 %h", obs_req_after, obs_pc_after, exp); end
    repeat (4) begin @(negedge clk); #1; if (imem_req === 1'b1) reqs++; end
    tests++; if (reqs !== 0) begin failed++; $display("[TB] FAIL stop_quiet: got %0d req cycles required 0", reqs); end
    model_pc = int'(exp);
    do_instr(OP_NOP, 8'h00, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tests++; if (obs_adr !== exp) begin failed++; $display("[TB] FAIL stop_resume: got %h required %h", obs_adr, exp); end
    model_pc = (model_pc + 1) % 256;
  endtask

  task automatic test_reset_mid_fetch();
    int waited = 0;
    do_instr(OP_GOTO, 8'h33, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run = 1'b1;
    #1;
    while (imem_req !== 1'b1 && waited < 20) begin @(negedge clk); #1; waited++; end
    tests++; if (imem_req !== 1'b1 || pc !== 8'h33) begin failed++;
      $display("[TB] FAIL pre_reset_fetch: req=%b pc=%h required 1 33", imem_req, pc); end
    reset = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0 || pc !== 8'h00) begin failed++;
      $display("[TB] FAIL reset_mid_fetch: req=%b pc=%h required 0 00", imem_req, pc); end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL reset_idle: req=%b required 0", imem_req); end
    model_pc = 0;
  endtask

`ifdef JAC_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int reqs = 0;
    do_instr(OP_ADD, 8'h00, 3'b000, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    tests++; if (obs_pc_after !== 8'(model_pc + 1) || obs_reg_strobes !== 1) begin failed++;
      $display("[TB] FAIL step_one: pc=%h strobes=%0d required %h 1", obs_pc_after, obs_reg_strobes, 8'(model_pc + 1)); end
    repeat (4) begin @(negedge clk); #1; if (imem_req === 1'b1) reqs++; end
    tests++; if (reqs !== 0) begin failed++; $display("[TB] FAIL step_idle: got %0d req cycles required 0", reqs); end
    model_pc = (model_pc + 1) % 256;
  endtask
`endif

  task automatic test_halt();
    int bad = 0;
    do_instr(OP_HALT, 8'h00, 3'b000, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    tests++; if (obs_halted !== 1'b1 || obs_req_after !== 1'b0) begin failed++;
      $display("[TB] FAIL halt_enter: halted=%b req=%b required 1 0", obs_halted, obs_req_after); end
    tests++; if (obs_reg_strobes !== 0 || obs_stat_strobes !== 0 || obs_pc_after !== 8'(model_pc)) begin failed++;
      $display("[TB] FAIL halt_side_effects: strobes=%0d/%0d pc=%h required 0/0 %h",
               obs_reg_strobes, obs_stat_strobes, obs_pc_after, 8'(model_pc)); end
    repeat (10) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    imem_ack = 1'b0;
    tests++; if (bad !== 0) begin failed++; $display("[TB] FAIL halt_absorb: %0d bad cycles required 0", bad); end
    reset = 1'b1;
    #1;
    tests++; if (halted !== 1'b0) begin failed++; $display("[TB] FAIL halt_reset: halted=%b required 0", halted); end
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_add();
    test_branches();
    test_wrap();
    test_random(40);
    test_run_stop();
`ifdef JAC_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_reset_mid_fetch();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
